// File: rtl/uart_recv.sv
`default_nettype none
// ============================================================================
// Module   : uart_recv
// Brief    : 8N1 UART receiver, LSB first, idle-high line. Two-flop input
//            synchroniser, mid-bit sampling with false-start rejection,
//            one-byte holding register with ready/ack handshake, sticky
//            overrun flag and frame-error pulse with break handling.
// Revision : 1.0 - initial release
// ============================================================================
module uart_recv #(
  parameter int CLOCK = 100000000,
  parameter int BAUD  = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Rx,
  input  logic       recv_ack,
  output logic [7:0] recv_data,
  output logic       recv_ready,
  output logic       recv_busy,
  output logic       frame_err,
  output logic       overrun
);

  // Clocks per bit and the counter sized to hold 0..CPB-1.
  localparam int CPB = CLOCK / BAUD;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;

  localparam logic [CW-1:0] c_cnt_last = CW'(CPB - 1);
  localparam logic [CW-1:0] c_cnt_half = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] c_cnt_one  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          brk_q;
  logic          rx_meta_q;
  logic          rx_s_q;
  logic          busy_q;
  logic          ferr_q;
  logic [7:0]    data_q;
  logic          ready_q;
  logic          over_q;
  logic          load_pulse;

  // Stop bit sampled high at mid-bit: the frame is good, hand it over.
  assign load_pulse = (state_q == S_STOP) && !brk_q &&
                      (cnt_q == c_cnt_last) && rx_s_q;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= Rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Frame FSM: start detection, mid-bit data sampling, stop check, break wait.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      brk_q   <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!rx_s_q) begin
            state_q <= S_START;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (cnt_q == c_cnt_half) begin
            cnt_q <= '0;
            if (!rx_s_q) begin
              state_q <= S_DATA;
              idx_q   <= '0;
            end else begin
              // Start bit gone by mid-bit: a glitch, quietly go back.
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + c_cnt_one;
          end
        end
        S_DATA: begin
          if (cnt_q == c_cnt_last) begin
            cnt_q   <= '0;
            shift_q <= {rx_s_q, shift_q[7:1]};
            idx_q   <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_q <= S_STOP;
            end
          end else begin
            cnt_q <= cnt_q + c_cnt_one;
          end
        end
        S_STOP: begin
          if (brk_q) begin
            // Line held low after a bad stop bit: wait for it to idle.
            if (rx_s_q) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              brk_q   <= 1'b0;
              cnt_q   <= '0;
            end
          end else if (cnt_q == c_cnt_last) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              ferr_q <= 1'b1;
              brk_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + c_cnt_one;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Holding register: load beats a same-cycle ack; unacked reload flags overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= 8'h00;
      ready_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      if (load_pulse) begin
        data_q  <= shift_q;
        ready_q <= 1'b1;
        if (ready_q && !recv_ack) begin
          over_q <= 1'b1;
        end else if (ready_q && recv_ack) begin
          over_q <= 1'b0;
        end
      end else if (recv_ack && ready_q) begin
        ready_q <= 1'b0;
        over_q  <= 1'b0;
      end
    end
  end

  assign recv_data  = data_q;
  assign recv_ready = ready_q;
  assign recv_busy  = busy_q;
  assign frame_err  = ferr_q;
  assign overrun    = over_q;

endmodule
`default_nettype wire
